key_bounce_gen: RTL and testbench
=================================

Name: key_bounce_gen

Overview:
Synthesizable mechanical-key emulator. It is the transmitting end of the key debounce interface. On command it drives a single-bit Key line through a complete press/release cycle:
- bounce on the falling edge,
- a stable low hold,
- bounce on the rising edge,
- a stable high settle.

Bounce intervals come from an internal LFSR, so waveforms are reproducible. It drives the key debouncer in benches and on-board self-test, and exposes the ideal clean level for comparison.

Parameters:
BOUNCE_CYC, 500000, length in cycles of each bounce phase (press and release); must be >=1
GLITCH_BITS, 12, LFSR bits used for the toggle interval; interval range is 1..2^GLITCH_BITS cycles; range 1..16
SETTLE_CYC, 1100000, stable-high cycles after release bounce before Done
SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
Start  input  1  one-cycle request to run one press/release sequence
Press_Cyc  input  32  stable-low hold length in cycles; latched on accepted Start
Key  output  1  emulated bouncy key line, idle high
Key_Ideal  output  1  clean reference level
Busy  output  1  sequence in progress
Done  output  1  one-cycle pulse when sequence completes

Behaviour:
- Clocking and reset: one clock (Clk); reset is synchronous and active-high (Reset).
- Reset values: Key=1, Key_Ideal=1, Busy=0, Done=0, state=IDLE, all counters=0, LFSR=SEED.
- Reset applies in every state. A mid-sequence reset aborts with no Done pulse.
- All outputs are registered.
- LFSR: 16-bit Galois, mask 16'hB400. It advances every cycle except in reset.
- Toggle interval = LFSR[GLITCH_BITS-1:0] + 1.

State machine:
- IDLE
  - Key=1, Busy=0.
  - Start accepted → latch Press_Cyc, with 0 treated as 1.
  - Next cycle: Busy=1, Key=0, Key_Ideal=0, enter P_BOUNCE.
  - Start while Busy is ignored. Press_Cyc changes after acceptance have no effect.
- P_BOUNCE
  - Lasts exactly BOUNCE_CYC cycles. The first cycle has Key=0 (first edge falling).
  - Toggle counter is loaded with the interval. When it expires, Key inverts and the counter reloads.
  - On the last phase cycle, Key is forced to 0 regardless of toggle expiry (phase end wins over toggle).
  - Then go to HOLD.
- HOLD
  - Key=0 stable for exactly the latched Press_Cyc cycles.
  - Then go to R_BOUNCE; its first cycle has Key=1 and Key_Ideal=1.
- R_BOUNCE
  - Mirror of P_BOUNCE. Lasts BOUNCE_CYC cycles; the final value is forced to 1.
  - Then go to SETTLE.
- SETTLE
  - Key=1 for exactly SETTLE_CYC cycles.
  - Next cycle: Done=1, Busy=0, state=IDLE.
  - A Start in the Done cycle is accepted.
- BOUNCE_CYC=1: the phase is a single clean edge with no toggles.

Timing and widths:
- Timing for Start sampled at edge N:
  - P_BOUNCE: N+1 .. N+BOUNCE_CYC
  - HOLD: follows P_BOUNCE
  - R_BOUNCE: follows HOLD
  - SETTLE: follows R_BOUNCE
  - Done: at N+1+2·BOUNCE_CYC+Press_Cyc+SETTLE_CYC
- Phase counter: 32 bits, no wrap within legal parameters.
- Toggle counter: GLITCH_BITS+1 bits.

Optional Feature:
Macro: KEY_GEN_EDGE_CNT_EN
- Defined: adds output Edge_Cnt, 16 bits.
  - Cleared on accepted Start and on reset.
  - Increments on every Key transition, including the forced edges.
  - Saturates at 16'hFFFF.
  - Holds its value after Done until the next Start.
- Undefined: no port and no counter logic.

Test Plan:
Sim parameters: BOUNCE_CYC=100, GLITCH_BITS=4, SETTLE_CYC=50, SEED=16'hACE1.
1. Reset held 3 cycles → Key=1, Key_Ideal=1, Busy=0, Done=0 for the duration and after release.
2. Start at N, Press_Cyc=20:
   - Key=0 and Busy=1 at N+1.
   - Key=0 at N+100 and stable through N+120.
   - Key=1 at N+220 and stable N+220..N+270.
   - Done=1 only at N+271, Busy=0 at N+271.
   - Every bounce run length is in 1..16.
3. Start pulsed again at N+50, and Press_Cyc changed to 5 at N+2 → no effect; Done still at N+271.
4. Press_Cyc=0 → HOLD lasts 1 cycle; Done at N+252.
5. Reset asserted during R_BOUNCE:
   - Next cycle: Key=1, Busy=0, no Done.
   - A fresh Start with Press_Cyc=20 reproduces the test-2 Key waveform bit-for-bit relative to Start.
6. With KEY_GEN_EDGE_CNT_EN: Edge_Cnt at Done equals the Key transitions counted by the bench, is even, and is ≥2. With BOUNCE_CYC=1, Edge_Cnt=2.

Source files
------------

// File: rtl/key_bounce_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : key_bounce_gen_if
// Description : Command/status bundle between a requester and the
//               key_bounce_gen mechanical-key emulator.
//   Start      - one-cycle request to run one press/release sequence
//   Press_Cyc  - stable-low hold length in cycles (latched on accepted Start)
//   Key        - emulated bouncy key line, idle high
//   Key_Ideal  - clean reference level
//   Busy       - sequence in progress
//   Done       - one-cycle pulse when a sequence completes
//   Edge_Cnt   - Key transition count (only with KEY_GEN_EDGE_CNT_EN)
// Modports    : master (requester side), slave (emulator side)
// Macro       : KEY_GEN_EDGE_CNT_EN adds Edge_Cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface key_bounce_gen_if;
  logic        Start;
  logic [31:0] Press_Cyc;
  logic        Key;
  logic        Key_Ideal;
  logic        Busy;
  logic        Done;
`ifdef KEY_GEN_EDGE_CNT_EN
  logic [15:0] Edge_Cnt;

  modport master (
    output Start, Press_Cyc,
    input  Key, Key_Ideal, Busy, Done, Edge_Cnt
  );
  modport slave (
    input  Start, Press_Cyc,
    output Key, Key_Ideal, Busy, Done, Edge_Cnt
  );
`else
  modport master (
    output Start, Press_Cyc,
    input  Key, Key_Ideal, Busy, Done
  );
  modport slave (
    input  Start, Press_Cyc,
    output Key, Key_Ideal, Busy, Done
  );
`endif
endinterface
`default_nettype wire

// File: rtl/key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : key_bounce_gen
// Description : Mechanical-key emulator. On Start it drives Key through a
//               falling bounce, a stable low hold, a rising bounce and a
//               stable high settle, then pulses Done. Bounce run lengths
//               come from a 16-bit Galois LFSR (mask 16'hB400), so the
//               waveform is reproducible from reset.
// Ports       : Clk    - system clock
//               Reset  - synchronous, active-high reset
//               bus    - key_bounce_gen_if.slave (Start, Press_Cyc in;
//                        Key, Key_Ideal, Busy, Done [, Edge_Cnt] out)
// Macro       : KEY_GEN_EDGE_CNT_EN adds the 16-bit saturating Edge_Cnt
// Revision    : 1.0 - initial release
// ============================================================================
module key_bounce_gen #(
  parameter int unsigned BOUNCE_CYC  = 500000,
  parameter int unsigned GLITCH_BITS = 12,
  parameter int unsigned SETTLE_CYC  = 1100000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic             Clk,
  input  logic             Reset,
  key_bounce_gen_if.slave  bus
);

  localparam logic [15:0] c_lfsr_mask   = 16'hB400;
  localparam logic [15:0] c_seed        = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [31:0] c_bounce_last = 32'(BOUNCE_CYC - 1);
  localparam logic [31:0] c_settle_last = 32'(SETTLE_CYC - 1);
  localparam int unsigned c_tog_w       = GLITCH_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_P_BOUNCE = 3'd1,
    S_HOLD     = 3'd2,
    S_R_BOUNCE = 3'd3,
    S_SETTLE   = 3'd4
  } state_t;

  state_t               r_state,     w_state_nxt;
  logic [31:0]          r_phase_cnt, w_phase_cnt_nxt;
  logic [31:0]          r_press,     w_press_nxt;
  logic [c_tog_w-1:0]   r_tog_cnt,   w_tog_cnt_nxt;
  logic [15:0]          r_lfsr,      w_lfsr_nxt;
  logic                 r_key,       w_key_nxt;
  logic                 r_key_ideal, w_key_ideal_nxt;
  logic                 r_busy,      w_busy_nxt;
  logic                 r_done,      w_done_nxt;
  logic [c_tog_w-1:0]   w_interval;
  logic [31:0]          w_phase_inc;
  logic                 w_accept;
  logic                 w_level;

  assign w_lfsr_nxt  = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_lfsr_mask : 16'h0000);
  assign w_interval  = c_tog_w'(r_lfsr[GLITCH_BITS-1:0]) + c_tog_w'(1);
  assign w_phase_inc = r_phase_cnt + 32'd1;
  assign w_accept    = (r_state == S_IDLE) && bus.Start;
  // Settled level of the current bounce phase: low for press, high for release.
  assign w_level     = (r_state == S_R_BOUNCE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_phase_cnt <= 32'd0;
      r_press     <= 32'd0;
      r_tog_cnt   <= '0;
      r_lfsr      <= c_seed;
      r_key       <= 1'b1;
      r_key_ideal <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase_cnt <= w_phase_cnt_nxt;
      r_press     <= w_press_nxt;
      r_tog_cnt   <= w_tog_cnt_nxt;
      r_lfsr      <= w_lfsr_nxt;
      r_key       <= w_key_nxt;
      r_key_ideal <= w_key_ideal_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_cnt_nxt = r_phase_cnt;
    w_press_nxt     = r_press;
    w_tog_cnt_nxt   = r_tog_cnt;
    w_key_nxt       = r_key;
    w_key_ideal_nxt = r_key_ideal;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_press_nxt     = (bus.Press_Cyc == 32'd0) ? 32'd1 : bus.Press_Cyc;
          w_state_nxt     = S_P_BOUNCE;
          w_phase_cnt_nxt = 32'd0;
          w_tog_cnt_nxt   = w_interval;
          w_key_nxt       = 1'b0;
          w_key_ideal_nxt = 1'b0;
          w_busy_nxt      = 1'b1;
        end
      end

      S_P_BOUNCE, S_R_BOUNCE: begin
        // Counter value 1 marks the last cycle of the current run.
        w_tog_cnt_nxt = (r_tog_cnt == c_tog_w'(1)) ? w_interval : r_tog_cnt - c_tog_w'(1);
        if (r_phase_cnt == c_bounce_last) begin
          w_phase_cnt_nxt = 32'd0;
          if (r_state == S_P_BOUNCE) begin
            w_state_nxt = S_HOLD;
            w_key_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_SETTLE;
            w_key_nxt   = 1'b1;
          end
        end else begin
          w_phase_cnt_nxt = w_phase_inc;
          // Phase end wins over a toggle landing on the final cycle.
          if (w_phase_inc == c_bounce_last) begin
            w_key_nxt = w_level;
          end else if (r_tog_cnt == c_tog_w'(1)) begin
            w_key_nxt = ~r_key;
          end
        end
      end

      S_HOLD: begin
        if (r_phase_cnt == r_press - 32'd1) begin
          w_state_nxt     = S_R_BOUNCE;
          w_phase_cnt_nxt = 32'd0;
          w_tog_cnt_nxt   = w_interval;
          w_key_nxt       = 1'b1;
          w_key_ideal_nxt = 1'b1;
        end else begin
          w_phase_cnt_nxt = w_phase_inc;
        end
      end

      S_SETTLE: begin
        if (r_phase_cnt == c_settle_last) begin
          w_state_nxt     = S_IDLE;
          w_phase_cnt_nxt = 32'd0;
          w_busy_nxt      = 1'b0;
          w_done_nxt      = 1'b1;
        end else begin
          w_phase_cnt_nxt = w_phase_inc;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_phase_cnt_nxt = 32'd0;
        w_key_nxt       = 1'b1;
        w_key_ideal_nxt = 1'b1;
        w_busy_nxt      = 1'b0;
      end
    endcase
  end

  assign bus.Key       = r_key;
  assign bus.Key_Ideal = r_key_ideal;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;

`ifdef KEY_GEN_EDGE_CNT_EN
  logic [15:0] r_edge_cnt;
  logic [15:0] w_edge_base;

  // An accepted Start clears the count, but the falling edge it causes
  // still counts, so the base is zero and the increment applies on top.
  assign w_edge_base = w_accept ? 16'h0000 : r_edge_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_edge_cnt <= 16'h0000;
    end else if ((w_key_nxt != r_key) && (w_edge_base != 16'hFFFF)) begin
      r_edge_cnt <= w_edge_base + 16'h0001;
    end else begin
      r_edge_cnt <= w_edge_base;
    end
  end

  assign bus.Edge_Cnt = r_edge_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_key_bounce_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_bounce_gen
// Description : Scoreboard bench for key_bounce_gen. Stimulus builds the
//               expected per-cycle waveform from the LFSR rules and queues
//               it; a monitor pops one record per cycle and compares.
//               A second instance with BOUNCE_CYC=1 covers the clean-edge
//               case. Macro KEY_GEN_EDGE_CNT_EN enables Edge_Cnt checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_bounce_gen;

  localparam int          B      = 100;
  localparam int          G      = 4;
  localparam int          S      = 50;
  localparam logic [15:0] SEED_V = 16'hACE1;

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  key_bounce_gen_if bus ();
  key_bounce_gen_if bus1 ();

  key_bounce_gen #(
    .BOUNCE_CYC (B),
    .GLITCH_BITS(G),
    .SETTLE_CYC (S),
    .SEED       (SEED_V)
  ) u_dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  key_bounce_gen #(
    .BOUNCE_CYC (1),
    .GLITCH_BITS(G),
    .SETTLE_CYC (3),
    .SEED       (SEED_V)
  ) u_dut1 (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus1)
  );

  typedef struct packed {
    logic        key;
    logic        ideal;
    logic        busy;
    logic        done;
    logic        bnc;    // inside a bounce phase, excluding its forced last cycle
    logic [15:0] edges;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_lfsr;
  logic        m_prev;
  logic [15:0] m_edges;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int ivl(input logic [15:0] l);
    return int'(l[G-1:0]) + 1;
  endfunction

  // Reference LFSR: value during each cycle, reloaded while in reset.
  always @(posedge Clk) m_lfsr <= Reset ? SEED_V : lfsr_step(m_lfsr);

  task automatic add(input logic k, input logic id, input logic bz, input logic dn, input logic bn);
    exp_t e;
    if (k != m_prev) m_edges = m_edges + 16'd1;
    m_prev  = k;
    e.key   = k;
    e.ideal = id;
    e.busy  = bz;
    e.done  = dn;
    e.bnc   = bn;
    e.edges = m_edges;
    exp_q.push_back(e);
  endtask

  // Expected waveform for a Start accepted while the LFSR holds l0.
  // A run starting in cycle c lasts ivl(LFSR value in cycle c-1).
  task automatic push_seq(input logic [15:0] l0, input logic [31:0] press);
    logic [15:0] l;
    int          hold;
    logic        base;
    logic        lvl;
    logic        v;
    int          left;
    l       = l0;
    hold    = (press == 0) ? 1 : int'(press);
    m_prev  = 1'b1;
    m_edges = 16'd0;
    for (int ph = 0; ph < 2; ph++) begin
      base = (ph == 1);
      lvl  = base;
      left = ivl(l);
      for (int p = 0; p < B; p++) begin
        l = lfsr_step(l);
        v = (p == B - 1) ? base : lvl;
        add(v, base, 1'b1, 1'b0, p != B - 1);
        left--;
        if (left == 0) begin
          lvl  = ~lvl;
          left = ivl(l);
        end
      end
      if (ph == 0) begin
        for (int h = 0; h < hold; h++) begin
          l = lfsr_step(l);
          add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
      end
    end
    for (int s = 0; s < S; s++) begin
      l = lfsr_step(l);
      add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    end
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: one sample per cycle, 1 time unit after the active edge.
  initial begin : g_monitor
    exp_t        e;
    int          run;
    logic        pk;
    logic        pb;
    logic [15:0] last_edges;
    run        = 0;
    pk         = 1'b1;
    pb         = 1'b0;
    last_edges = 16'd0;
    forever begin
      @(posedge Clk);
      #1;
      if (Reset) last_edges = 16'd0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.Key, bus.Key_Ideal, bus.Busy, bus.Done} !== {e.key, e.ideal, e.busy, e.done}) begin
          errors++;
          $display("FAIL seq_cycle @%0t: key/ideal/busy/done got %b%b%b%b required %b%b%b%b",
                   $time, bus.Key, bus.Key_Ideal, bus.Busy, bus.Done, e.key, e.ideal, e.busy, e.done);
        end
`ifdef KEY_GEN_EDGE_CNT_EN
        checks++;
        if (bus.Edge_Cnt !== e.edges) begin
          errors++;
          $display("FAIL edge_cnt @%0t: got %0d required %0d", $time, bus.Edge_Cnt, e.edges);
        end
        if (e.done) begin
          checks++;
          if (bus.Edge_Cnt[0] !== 1'b0 || bus.Edge_Cnt < 16'd2) begin
            errors++;
            $display("FAIL edge_cnt_even @%0t: got %0d required even and >=2", $time, bus.Edge_Cnt);
          end
        end
        last_edges = e.edges;
`endif
        if (e.bnc) begin
          if (pb && bus.Key !== pk) begin
            checks++;
            if (run < 1 || run > 16) begin
              errors++;
              $display("FAIL run_len @%0t: got %0d required 1..16", $time, run);
            end
            run = 1;
          end else if (pb) begin
            run++;
          end else begin
            run = 1;
          end
        end
        pb = e.bnc;
        pk = bus.Key;
      end else begin
        checks++;
        if ({bus.Key, bus.Key_Ideal, bus.Busy, bus.Done} !== 4'b1100) begin
          errors++;
          $display("FAIL idle @%0t: key/ideal/busy/done got %b%b%b%b required 1100",
                   $time, bus.Key, bus.Key_Ideal, bus.Busy, bus.Done);
        end
`ifdef KEY_GEN_EDGE_CNT_EN
        checks++;
        if (bus.Edge_Cnt !== last_edges) begin
          errors++;
          $display("FAIL edge_hold @%0t: got %0d required %0d", $time, bus.Edge_Cnt, last_edges);
        end
`endif
        pb = 1'b0;
      end
    end
  end

  task automatic do_reset();
    exp_q.delete();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  // Called at the negedge of the Start cycle; returns at the negedge of the
  // last busy cycle with Start low. mode: 0 quiet, 1 fixed disturb, 2 random.
  task automatic run_seq(input logic [31:0] press, input int mode);
    int hold;
    int len;
    hold = (press == 0) ? 1 : int'(press);
    len  = 1 + 2 * B + hold + S;
    bus.Start     = 1'b1;
    bus.Press_Cyc = press;
    push_seq(m_lfsr, press);
    for (int i = 1; i < len; i++) begin
      @(negedge Clk);
      bus.Start = 1'b0;
      if (mode == 1) begin
        if (i == 2)  bus.Press_Cyc = 32'd5;
        if (i == 50) bus.Start = 1'b1;
      end else if (mode == 2 && i < len - 1) begin
        bus.Start = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 7) == 0) bus.Press_Cyc = $urandom_range(0, 60);
      end
    end
  endtask

  initial begin : g_stim
    logic [8:1] k1;
    bus.Start      = 1'b0;
    bus.Press_Cyc  = 32'd0;
    bus1.Start     = 1'b0;
    bus1.Press_Cyc = 32'd0;

    do_reset();
    run_seq(32'd20, 0);
    @(negedge Clk);
    repeat (2) @(negedge Clk);
    run_seq(32'd20, 1);
    @(negedge Clk);
    run_seq(32'd0, 0);
    @(negedge Clk);

    // Abort in R_BOUNCE, then replay the first sequence from the same offset.
    bus.Start     = 1'b1;
    bus.Press_Cyc = 32'd20;
    push_seq(m_lfsr, 32'd20);
    repeat (150) begin
      @(negedge Clk);
      bus.Start = 1'b0;
    end
    do_reset();
    run_seq(32'd20, 0);

    for (int r = 0; r < 6; r++) begin
      @(negedge Clk);
      repeat ($urandom_range(0, 3)) @(negedge Clk);
      run_seq($urandom_range(0, 40), 2);
    end
    @(negedge Clk);

    // Single-cycle bounce phases: clean edges only.
    k1 = 8'b1111_1000;
    bus1.Start     = 1'b1;
    bus1.Press_Cyc = 32'd2;
    for (int k = 1; k <= 8; k++) begin
      @(posedge Clk);
      #1;
      if (k == 1) bus1.Start = 1'b0;
      checks++;
      if (bus1.Key !== k1[k] || bus1.Done !== (k == 8) || bus1.Busy !== (k != 8)) begin
        errors++;
        $display("FAIL b1_cycle%0d: key/busy/done got %b%b%b required %b%b%b",
                 k, bus1.Key, bus1.Busy, bus1.Done, k1[k], k != 8, k == 8);
      end
`ifdef KEY_GEN_EDGE_CNT_EN
      if (k == 8) begin
        checks++;
        if (bus1.Edge_Cnt !== 16'd2) begin
          errors++;
          $display("FAIL b1_edge_cnt: got %0d required 2", bus1.Edge_Cnt);
        end
      end
`endif
    end

    repeat (5) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d records left required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
